noc_outport_arbiter: RTL and testbench



---
 rtl/noc_outport_arbiter.sv | 157 +++++++++++++++
 tb/tb_noc_outport_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_outport_arbiter.sv
// rtl/noc_outport_arbiter.sv - round-robin wormhole output-port arbiter with downstream credit tracking
module noc_outport_arbiter #(
    parameter int LL      = 16,
    parameter int N       = 4,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N*LL-1:0]   flit_in,
    input  logic              credit_in,
    output logic [N-1:0]      pop,
    output logic [N-1:0]      grant,
    output logic [LL-1:0]     out_flit,
    output logic              out_valid,
    output logic [CW-1:0]     credits,
    output logic              err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cred_q;
    logic            err_q;

    logic [LL-1:0]   flits [N];
    logic [IW-1:0]   winner;
    logic            found;
    logic [IW-1:0]   sel;
    logic [LL-1:0]   flit_sel;
    logic [1:0]      ftype;
    logic            has_credit;
    logic            sel_vld;
    logic            fwd;
    logic            proto_err;
    logic            cred_ovf;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            flits[i] = flit_in[i*LL +: LL];
        end
    end

    // Round-robin search starts just after the last served port.
    always_comb begin
        logic [IW-1:0] cand;
        winner = rr_q;
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(rr_q) + k) % N);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign sel        = (state_q == LOCKED) ? owner_q : winner;
    assign flit_sel   = flits[sel];
    assign ftype      = flit_sel[LL-1 -: 2];
    assign has_credit = (cred_q != '0);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        sel_vld   = 1'b0;
        fwd       = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (has_credit && found) begin
                    sel_vld = 1'b1;
                    case (ftype)
                        T_HEAD: begin
                            fwd     = 1'b1;
                            state_d = LOCKED;
                            owner_d = winner;
                        end
                        T_SINGLE: begin
                            fwd  = 1'b1;
                            rr_d = winner;
                        end
                        default: begin
                            // Orphan body/tail: drained so the input cannot stall forever.
                            proto_err = 1'b1;
                            rr_d      = winner;
                        end
                    endcase
                end
            end
            LOCKED: begin
                if (req[owner_q] && has_credit) begin
                    sel_vld = 1'b1;
                    fwd     = 1'b1;
                    if (ftype == T_TAIL) begin
                        state_d = IDLE;
                        rr_d    = owner_q;
                    end else if (ftype == T_HEAD || ftype == T_SINGLE) begin
                        proto_err = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop = '0;
        if (sel_vld && !reset) begin
            pop[sel] = 1'b1;
        end
    end

    assign cred_ovf = credit_in && !fwd && (cred_q == CRED_MAX);
    assign grant    = (state_q == LOCKED) ? (N'(1) << owner_q) : '0;
    assign credits  = cred_q;
    assign err      = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= IW'(N - 1);
            cred_q    <= CRED_MAX;
            err_q     <= 1'b0;
            out_flit  <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            err_q     <= err_q | proto_err | cred_ovf;
            out_valid <= fwd;
            if (fwd) begin
                out_flit <= flit_sel;
            end
            // Saturating at both ends: overflow is flagged, never wrapped.
            if (fwd && !credit_in) begin
                cred_q <= cred_q - 1'b1;
            end else if (credit_in && !fwd && !cred_ovf) begin
                cred_q <= cred_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// tb/tb_noc_outport_arbiter.sv - randomized and directed bench with packet-level reference model
module tb_noc_outport_arbiter;
    localparam int LL = 16;
    localparam int N = 4;
    localparam int CREDITS = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*LL-1:0] flit_in = '0;
    logic            credit_in = 1'b0;
    logic [N-1:0]    pop;
    logic [N-1:0]    grant;
    logic [LL-1:0]   out_flit;
    logic            out_valid;
    logic [CW-1:0]   credits;
    logic            err;

    noc_outport_arbiter #(.LL(LL), .N(N), .CREDITS(CREDITS), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .flit_in(flit_in), .credit_in(credit_in),
        .pop(pop), .grant(grant), .out_flit(out_flit), .out_valid(out_valid),
        .credits(credits), .err(err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    logic [LL-1:0] fl [N];

    bit m_locked;
    int m_owner;
    int m_rr;
    int m_cred;
    bit m_err;

    task automatic model_reset();
        m_locked = 0;
        m_owner = 0;
        m_rr = N - 1;
        m_cred = CREDITS;
        m_err = 0;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic ci);
        req = r;
        credit_in = ci;
        for (int i = 0; i < N; i++) flit_in[i*LL +: LL] = fl[i];
    endtask

    // One cycle: inputs applied after a rising edge, pop checked mid-cycle, registers checked after the next edge.
    task automatic step(input logic [N-1:0] r, input logic ci, input string tag, output int w);
        logic [N-1:0] exp_pop;
        logic [N-1:0] exp_grant;
        logic [LL-1:0] f;
        int typ;
        bit fwd;
        drive(r, ci);
        w = -1;
        f = '0;
        if (!m_locked) begin
            if (m_cred > 0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (w < 0 && r[idx]) w = idx;
                end
            end
        end else if (r[m_owner] && m_cred > 0) begin
            w = m_owner;
        end
        exp_pop = (w >= 0) ? (N'(1) << w) : '0;
        @(negedge clk);
        n_assert++;
        if (pop !== exp_pop) begin
            n_fail++;
            $display("FAIL %s pop: got %b expected %b", tag, pop, exp_pop);
        end
        fwd = 0;
        if (w >= 0) begin
            f = fl[w];
            typ = int'(f[LL-1 -: 2]);
            if (!m_locked) begin
                if (typ == 1) begin
                    fwd = 1; m_locked = 1; m_owner = w;
                end else if (typ == 3) begin
                    fwd = 1; m_rr = w;
                end else begin
                    m_err = 1; m_rr = w;
                end
            end else begin
                fwd = 1;
                if (typ == 2) begin
                    m_locked = 0; m_rr = m_owner;
                end else if (typ != 0) begin
                    m_err = 1;
                end
            end
        end
        if (fwd && !ci) m_cred = m_cred - 1;
        else if (ci && !fwd) begin
            if (m_cred == CREDITS) m_err = 1;
            else m_cred = m_cred + 1;
        end
        exp_grant = m_locked ? (N'(1) << m_owner) : '0;
        @(posedge clk);
        #1;
        n_assert++;
        if (out_valid !== fwd) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, fwd);
        end
        if (fwd) begin
            n_assert++;
            if (out_flit !== f) begin
                n_fail++;
                $display("FAIL %s out_flit: got %h expected %h", tag, out_flit, f);
            end
        end
        n_assert++;
        if (credits !== CW'(m_cred)) begin
            n_fail++;
            $display("FAIL %s credits: got %0d expected %0d", tag, credits, m_cred);
        end
        n_assert++;
        if (grant !== exp_grant) begin
            n_fail++;
            $display("FAIL %s grant: got %b expected %b", tag, grant, exp_grant);
        end
        n_assert++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", tag, err, m_err);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) fl[i] = 16'hC000 | 16'(i);
        drive('1, 1'b1);
        @(negedge clk);
        n_assert++;
        if (pop !== '0 || grant !== '0 || out_valid !== 1'b0 || out_flit !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got pop=%b grant=%b ov=%b of=%h expected all zero",
                     pop, grant, out_valid, out_flit);
        end
        n_assert++;
        if (credits !== CW'(CREDITS) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset credits/err: got %0d/%b expected %0d/0", credits, err, CREDITS);
        end
        do_reset();
    endtask

    task automatic test_single();
        int w;
        fl[0] = 16'hC0A5;
        step(4'b0001, 1'b0, "single", w);
        n_assert++;
        if (out_valid !== 1'b1 || out_flit !== 16'hC0A5 || credits !== 3'd3) begin
            n_fail++;
            $display("FAIL single_fwd: got ov=%b of=%h cr=%0d expected 1 c0a5 3", out_valid, out_flit, credits);
        end
    endtask

    task automatic test_round_robin();
        int w;
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) fl[i] = 16'hC100 | 16'(i);
        for (int s = 0; s < 5; s++) begin
            step(4'b1111, 1'b1, "rr", w);
            n_assert++;
            if (w != exp_seq[s] || credits !== 3'd4) begin
                n_fail++;
                $display("FAIL rr_seq step %0d: got winner %0d credits %0d expected %0d 4", s, w, credits, exp_seq[s]);
            end
        end
    endtask

    task automatic test_wormhole();
        int w;
        do_reset();
        fl[1] = 16'hC011;
        fl[2] = 16'h4022;
        step(4'b0100, 1'b1, "worm_head", w);
        fl[2] = 16'h0023;
        step(4'b0110, 1'b1, "worm_body", w);
        n_assert++;
        if (w != 2 || grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL worm_lock: got winner %0d grant %b expected 2 0100", w, grant);
        end
        fl[2] = 16'h8024;
        step(4'b0110, 1'b1, "worm_tail", w);
        n_assert++;
        if (w != 2 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL worm_tail: got winner %0d grant %b expected 2 0000", w, grant);
        end
        step(4'b0010, 1'b1, "worm_next", w);
        n_assert++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL worm_next: got winner %0d expected 1", w);
        end
    endtask

    task automatic test_credits();
        int w;
        int npop;
        do_reset();
        npop = 0;
        for (int s = 0; s < 6; s++) begin
            fl[0] = 16'hC200 | 16'(s);
            step(4'b0001, 1'b0, "cred_drain", w);
            if (w >= 0) npop++;
        end
        n_assert++;
        if (npop != 4 || credits !== 3'd0) begin
            n_fail++;
            $display("FAIL cred_drain: got %0d pops credits %0d expected 4 0", npop, credits);
        end
        npop = 0;
        step(4'b0001, 1'b1, "cred_return", w);
        if (w >= 0) npop++;
        for (int s = 0; s < 2; s++) begin
            step(4'b0001, 1'b0, "cred_one", w);
            if (w >= 0) npop++;
        end
        n_assert++;
        if (npop != 1) begin
            n_fail++;
            $display("FAIL cred_one: got %0d pops expected 1", npop);
        end
    endtask

    task automatic test_discard();
        int w;
        do_reset();
        fl[3] = 16'h1234;
        step(4'b1000, 1'b0, "discard", w);
        n_assert++;
        if (w != 3 || err !== 1'b1 || out_valid !== 1'b0 || credits !== 3'd4) begin
            n_fail++;
            $display("FAIL discard: got w=%0d err=%b ov=%b cr=%0d expected 3 1 0 4", w, err, out_valid, credits);
        end
    endtask

    task automatic test_async_reset();
        int w;
        do_reset();
        fl[1] = 16'h4001;
        step(4'b0010, 1'b0, "ar_head", w);
        fl[1] = 16'h0002;
        step(4'b0010, 1'b0, "ar_body1", w);
        step(4'b0010, 1'b0, "ar_body2", w);
        #3;
        reset = 1'b1;
        #1;
        n_assert++;
        if (pop !== '0 || grant !== '0 || out_valid !== 1'b0 || out_flit !== '0 ||
            credits !== 3'd4 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got pop=%b grant=%b ov=%b of=%h cr=%0d err=%b expected 0 0 0 0 4 0",
                     pop, grant, out_valid, out_flit, credits, err);
        end
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < N; i++) fl[i] = 16'hC300 | 16'(i);
        step(4'b1111, 1'b0, "ar_first", w);
        n_assert++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL ar_first: got winner %0d expected 0", w);
        end
    endtask

    task automatic test_random();
        int w;
        do_reset();
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < N; i++) fl[i] = 16'($urandom);
            step(N'($urandom), ($urandom_range(0, 2) == 0), "rand", w);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_wormhole();
        test_credits();
        test_discard();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
